// File: rtl/bolme_denetleyici_pkg.sv
// Shared definitions for the divide sequencer: operation codes, FSM states,
// watchdog default and the result-cache entry layout.
package bolme_denetleyici_pkg;

    localparam logic [1:0] BOLME_DIVU = 2'b00;
    localparam logic [1:0] BOLME_REMU = 2'b01;
    localparam logic [1:0] BOLME_DIV  = 2'b10;
    localparam logic [1:0] BOLME_REM  = 2'b11;

    localparam int unsigned BEKLEME_SINIRI_VARSAYILAN = 40;

    typedef enum logic [1:0] {
        BD_BOS     = 2'd0,
        BD_BOLUYOR = 2'd1,
        BD_TAMAM   = 2'd2
    } bd_durum_e;

    typedef struct packed {
        logic        gecerli;
        logic [1:0]  islem;
        logic [31:0] bolunen;
        logic [31:0] bolen;
        logic [31:0] sonuc;
    } onbellek_kaydi_t;

endpackage

// File: rtl/bolme_onbellek.sv
// Single-entry divide result cache: exact key compare on (islem, bolunen, bolen),
// overwritten on every completed divide, cleared only by reset.
module bolme_onbellek
    import bolme_denetleyici_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  sorgu_islem_i,
    input  logic [31:0] sorgu_bolunen_i,
    input  logic [31:0] sorgu_bolen_i,
    output logic        isabet_o,
    output logic [31:0] sonuc_o,
    input  logic        yaz_i,
    input  logic [1:0]  yaz_islem_i,
    input  logic [31:0] yaz_bolunen_i,
    input  logic [31:0] yaz_bolen_i,
    input  logic [31:0] yaz_sonuc_i
);

    onbellek_kaydi_t kayit_q, kayit_d;

    always_comb begin
        kayit_d = kayit_q;
        if (yaz_i) begin
            kayit_d.gecerli = 1'b1;
            kayit_d.islem   = yaz_islem_i;
            kayit_d.bolunen = yaz_bolunen_i;
            kayit_d.bolen   = yaz_bolen_i;
            kayit_d.sonuc   = yaz_sonuc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kayit_q <= '0;
        end else begin
            kayit_q <= kayit_d;
        end
    end

    assign isabet_o = kayit_q.gecerli
                    && (kayit_q.islem   == sorgu_islem_i)
                    && (kayit_q.bolunen == sorgu_bolunen_i)
                    && (kayit_q.bolen   == sorgu_bolen_i);
    assign sonuc_o  = kayit_q.sonuc;

endmodule

// File: rtl/bolme_denetleyici.sv
// Execute-stage divide sequencer feeding bolme_birimi; stalls issue until the
// result is retired. Optional result cache enabled by BOLME_ONBELLEK_EN.
module bolme_denetleyici
    import bolme_denetleyici_pkg::*;
#(
    parameter int unsigned BEKLEME_SINIRI = BEKLEME_SINIRI_VARSAYILAN,
    parameter int unsigned SAYAC_W        = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        gecerli_i,
    input  logic [1:0]  islem_i,
    input  logic [31:0] bolunen_i,
    input  logic [31:0] bolen_i,
    input  logic        bosalt_i,
    input  logic        durdur_i,
    output logic        duraklat_o,
    output logic [31:0] sonuc_o,
    output logic        sonuc_gecerli_o,
    output logic        hata_o,
    output logic        bolme_basla_o,
    output logic [1:0]  bolme_islem_o,
    output logic [31:0] bolme_bolunen_o,
    output logic [31:0] bolme_bolen_o,
    input  logic [31:0] bolme_sonuc_i,
    input  logic        bolme_bitti_i
);

    bd_durum_e           durum_q, durum_d;
    logic [1:0]          islem_q, islem_d;
    logic [31:0]         bolunen_q, bolunen_d;
    logic [31:0]         bolen_q, bolen_d;
    logic [31:0]         sonuc_q, sonuc_d;
    logic [SAYAC_W-1:0]  sayac_q, sayac_d;
    logic                hata_q, hata_d;
    logic                isabet;
    logic [31:0]         onbellek_sonuc;

`ifdef BOLME_ONBELLEK_EN
    logic onbellek_yaz;
    assign onbellek_yaz = (durum_q == BD_BOLUYOR) && bolme_bitti_i && !bosalt_i;

    bolme_onbellek u_onbellek (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .sorgu_islem_i   (islem_i),
        .sorgu_bolunen_i (bolunen_i),
        .sorgu_bolen_i   (bolen_i),
        .isabet_o        (isabet),
        .sonuc_o         (onbellek_sonuc),
        .yaz_i           (onbellek_yaz),
        .yaz_islem_i     (islem_q),
        .yaz_bolunen_i   (bolunen_q),
        .yaz_bolen_i     (bolen_q),
        .yaz_sonuc_i     (bolme_sonuc_i)
    );
`else
    assign isabet         = 1'b0;
    assign onbellek_sonuc = '0;
`endif

    always_comb begin
        durum_d         = durum_q;
        islem_d         = islem_q;
        bolunen_d       = bolunen_q;
        bolen_d         = bolen_q;
        sonuc_d         = sonuc_q;
        sayac_d         = sayac_q;
        hata_d          = 1'b0;
        duraklat_o      = 1'b0;
        bolme_basla_o   = 1'b0;
        sonuc_gecerli_o = 1'b0;

        case (durum_q)
            BD_BOS: begin
                duraklat_o = gecerli_i;
                if (gecerli_i && !bosalt_i) begin
                    islem_d   = islem_i;
                    bolunen_d = bolunen_i;
                    bolen_d   = bolen_i;
                    sayac_d   = '0;
                    if (isabet) begin
                        sonuc_d = onbellek_sonuc;
                        durum_d = BD_TAMAM;
                    end else begin
                        durum_d = BD_BOLUYOR;
                    end
                end
            end
            BD_BOLUYOR: begin
                bolme_basla_o = 1'b1;
                duraklat_o    = 1'b1;
                sayac_d       = sayac_q + 1'b1;
                // Completion is checked first so it beats a same-cycle watchdog expiry.
                if (bolme_bitti_i) begin
                    sonuc_d = bolme_sonuc_i;
                    durum_d = BD_TAMAM;
                end else if (sayac_q == SAYAC_W'(BEKLEME_SINIRI - 1)) begin
                    hata_d  = 1'b1;
                    durum_d = BD_BOS;
                end
            end
            BD_TAMAM: begin
                sonuc_gecerli_o = 1'b1;
                duraklat_o      = durdur_i;
                if (!durdur_i) begin
                    durum_d = BD_BOS;
                end
            end
            default: begin
                durum_d = BD_BOS;
            end
        endcase

        if (bosalt_i) begin
            durum_d = BD_BOS;
            sonuc_d = sonuc_q;
            hata_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q   <= BD_BOS;
            islem_q   <= '0;
            bolunen_q <= '0;
            bolen_q   <= '0;
            sonuc_q   <= '0;
            sayac_q   <= '0;
            hata_q    <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            islem_q   <= islem_d;
            bolunen_q <= bolunen_d;
            bolen_q   <= bolen_d;
            sonuc_q   <= sonuc_d;
            sayac_q   <= sayac_d;
            hata_q    <= hata_d;
        end
    end

    assign sonuc_o         = sonuc_q;
    assign hata_o          = hata_q;
    assign bolme_islem_o   = islem_q;
    assign bolme_bolunen_o = bolunen_q;
    assign bolme_bolen_o   = bolen_q;

endmodule

// File: tb/tb_bolme_denetleyici.sv
// Directed bench for bolme_denetleyici with a behavioural 35-cycle divider model.
module tb_bolme_denetleyici;

    logic        clk = 1'b0;
    logic        rst;
    logic        gecerli;
    logic [1:0]  islem;
    logic [31:0] bolunen;
    logic [31:0] bolen;
    logic        bosalt;
    logic        durdur;
    logic        duraklat;
    logic [31:0] sonuc;
    logic        sonuc_gecerli;
    logic        hata;
    logic        basla;
    logic [1:0]  b_islem;
    logic [31:0] b_bolunen;
    logic [31:0] b_bolen;
    logic [31:0] b_sonuc;
    logic        b_bitti;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bolme_denetleyici #(
        .BEKLEME_SINIRI (40),
        .SAYAC_W        (6)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .gecerli_i       (gecerli),
        .islem_i         (islem),
        .bolunen_i       (bolunen),
        .bolen_i         (bolen),
        .bosalt_i        (bosalt),
        .durdur_i        (durdur),
        .duraklat_o      (duraklat),
        .sonuc_o         (sonuc),
        .sonuc_gecerli_o (sonuc_gecerli),
        .hata_o          (hata),
        .bolme_basla_o   (basla),
        .bolme_islem_o   (b_islem),
        .bolme_bolunen_o (b_bolunen),
        .bolme_bolen_o   (b_bolen),
        .bolme_sonuc_i   (b_sonuc),
        .bolme_bitti_i   (b_bitti)
    );

    // Divider model: result and bitti appear in the 35th consecutive basla cycle.
    logic [5:0] k_q;
    logic       stub_sifir;

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] allones;
        allones = '1;
        case (op)
            2'b00: return (b == 0) ? allones : a / b;
            2'b01: return (b == 0) ? a : a % b;
            2'b10: begin
                if (b == 0) return allones;
                if (a == 32'h8000_0000 && b == allones) return a;
                return $unsigned($signed(a) / $signed(b));
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == allones) return '0;
                return $unsigned($signed(a) % $signed(b));
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (!basla) k_q <= '0;
        else        k_q <= k_q + 6'd1;
    end

    assign b_bitti = stub_sifir ? 1'b0 : (!basla || k_q == 6'd34);
    assign b_sonuc = (basla && k_q == 6'd34) ? ref_div(b_islem, b_bolunen, b_bolen) : 32'hDEAD_BEEF;

    task automatic adim();
        @(posedge clk);
        #1;
    endtask

    task automatic istek(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        gecerli = 1'b1;
        islem   = op;
        bolunen = a;
        bolen   = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adim();
        adim();
        @(negedge clk);
        checks++;
        if ({duraklat, sonuc_gecerli, hata, basla} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 0000", {duraklat, sonuc_gecerli, hata, basla});
        end
        checks++;
        if ({sonuc, b_islem, b_bolunen, b_bolen} !== '0) begin
            errors++;
            $display("FAIL reset_data sonuc=%h islem=%b a=%h b=%h exp all 0", sonuc, b_islem, b_bolunen, b_bolen);
        end
        rst = 1'b0;
    endtask

    task automatic test_div_neg();
        for (int j = 0; j <= 36; j++) begin
            adim();
            if (j == 0) istek(2'b10, 32'hFFFF_FFF9, 32'd2);
            else        gecerli = 1'b0;
            @(negedge clk);
            checks++;
            if (basla !== (j >= 1 && j <= 35)) begin
                errors++;
                $display("FAIL div_basla j=%0d got %b exp %b", j, basla, (j >= 1 && j <= 35));
            end
            checks++;
            if (sonuc_gecerli !== (j == 36)) begin
                errors++;
                $display("FAIL div_gecerli j=%0d got %b exp %b", j, sonuc_gecerli, (j == 36));
            end
            checks++;
            if (duraklat !== (j <= 35)) begin
                errors++;
                $display("FAIL div_duraklat j=%0d got %b exp %b", j, duraklat, (j <= 35));
            end
            if (j == 1) begin
                checks++;
                if ({b_islem, b_bolunen, b_bolen} !== {2'b10, 32'hFFFF_FFF9, 32'd2}) begin
                    errors++;
                    $display("FAIL div_operands got %b %h %h exp 10 fffffff9 00000002", b_islem, b_bolunen, b_bolen);
                end
            end
            if (j == 36) begin
                checks++;
                if (sonuc !== 32'hFFFF_FFFD) begin
                    errors++;
                    $display("FAIL div_sonuc got %h exp fffffffd", sonuc);
                end
            end
        end
    endtask

    task automatic test_durdur();
        for (int j = 0; j <= 40; j++) begin
            adim();
            if (j == 0) istek(2'b01, 32'd100, 32'd0);
            else        gecerli = 1'b0;
            durdur = (j >= 36 && j <= 38);
            @(negedge clk);
            checks++;
            if (sonuc_gecerli !== (j >= 36 && j <= 39)) begin
                errors++;
                $display("FAIL durdur_gecerli j=%0d got %b exp %b", j, sonuc_gecerli, (j >= 36 && j <= 39));
            end
            checks++;
            if (duraklat !== (j <= 38)) begin
                errors++;
                $display("FAIL durdur_duraklat j=%0d got %b exp %b", j, duraklat, (j <= 38));
            end
            if (j >= 36 && j <= 39) begin
                checks++;
                if (sonuc !== 32'd100) begin
                    errors++;
                    $display("FAIL durdur_sonuc j=%0d got %0d exp 100", j, sonuc);
                end
            end
        end
        durdur = 1'b0;
    endtask

    task automatic test_bosalt();
        for (int j = 0; j <= 47; j++) begin
            adim();
            gecerli = 1'b0;
            if (j == 0)  istek(2'b00, 32'hFFFF_FFFF, 32'd3);
            bosalt = (j == 10);
            if (j == 11) istek(2'b00, 32'd10, 32'd3);
            @(negedge clk);
            checks++;
            if (basla !== ((j >= 1 && j <= 10) || (j >= 12 && j <= 46))) begin
                errors++;
                $display("FAIL bosalt_basla j=%0d got %b", j, basla);
            end
            checks++;
            if (sonuc_gecerli !== (j == 47) || hata !== 1'b0) begin
                errors++;
                $display("FAIL bosalt_gecerli_hata j=%0d got %b%b exp %b0", j, sonuc_gecerli, hata, (j == 47));
            end
            if (j == 11) begin
                checks++;
                if (duraklat !== 1'b1) begin
                    errors++;
                    $display("FAIL bosalt_accept_duraklat got %b exp 1", duraklat);
                end
            end
            if (j == 47) begin
                checks++;
                if (sonuc !== 32'd3) begin
                    errors++;
                    $display("FAIL bosalt_sonuc got %0d exp 3", sonuc);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        stub_sifir = 1'b1;
        for (int j = 0; j <= 42; j++) begin
            adim();
            if (j == 0) istek(2'b00, 32'd5, 32'd1);
            else        gecerli = 1'b0;
            @(negedge clk);
            checks++;
            if (basla !== (j >= 1 && j <= 40)) begin
                errors++;
                $display("FAIL wd_basla j=%0d got %b exp %b", j, basla, (j >= 1 && j <= 40));
            end
            checks++;
            if (hata !== (j == 41)) begin
                errors++;
                $display("FAIL wd_hata j=%0d got %b exp %b", j, hata, (j == 41));
            end
            checks++;
            if (sonuc_gecerli !== 1'b0 || duraklat !== (j <= 40)) begin
                errors++;
                $display("FAIL wd_ctl j=%0d gecerli=%b duraklat=%b exp 0 %b", j, sonuc_gecerli, duraklat, (j <= 40));
            end
        end
        stub_sifir = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j <= 21; j++) begin
            adim();
            if (j == 0) istek(2'b10, 32'd1234, 32'd7);
            else        gecerli = 1'b0;
            rst = (j == 20);
            @(negedge clk);
            if (j == 20) begin
                checks++;
                if (basla !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_busy got %b exp 1", basla);
                end
            end
        end
        checks++;
        if ({duraklat, sonuc_gecerli, hata, basla, b_islem, b_bolunen, b_bolen, sonuc} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs ctl=%b%b%b%b islem=%b a=%h b=%h s=%h exp all 0",
                     duraklat, sonuc_gecerli, hata, basla, b_islem, b_bolunen, b_bolen, sonuc);
        end
        for (int j = 0; j <= 36; j++) begin
            adim();
            if (j == 0) istek(2'b11, 32'd7, 32'hFFFF_FFFE);
            else        gecerli = 1'b0;
            @(negedge clk);
            checks++;
            if (sonuc_gecerli !== (j == 36)) begin
                errors++;
                $display("FAIL rem_gecerli j=%0d got %b exp %b", j, sonuc_gecerli, (j == 36));
            end
            if (j == 36) begin
                checks++;
                if (sonuc !== 32'd1) begin
                    errors++;
                    $display("FAIL rem_sonuc got %0d exp 1", sonuc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int r2;
        int c;
        logic exp_basla;
`ifdef BOLME_ONBELLEK_EN
        r2 = 38;
`else
        r2 = 73;
`endif
        c = r2 + 1;
        for (int j = 0; j <= c + 36; j++) begin
            adim();
            gecerli = 1'b0;
            if (j == 0 || j == 37) istek(2'b00, 32'd1000, 32'd10);
            if (j == c)            istek(2'b00, 32'd1000, 32'd8);
            @(negedge clk);
            exp_basla = (j >= 1 && j <= 35) || (j >= c + 1 && j <= c + 35) || (r2 == 73 && j >= 38 && j <= 72);
            checks++;
            if (basla !== exp_basla) begin
                errors++;
                $display("FAIL b2b_basla j=%0d got %b exp %b", j, basla, exp_basla);
            end
            checks++;
            if (sonuc_gecerli !== (j == 36 || j == r2 || j == c + 36)) begin
                errors++;
                $display("FAIL b2b_gecerli j=%0d got %b", j, sonuc_gecerli);
            end
            if (j == 36 || j == r2) begin
                checks++;
                if (sonuc !== 32'd100) begin
                    errors++;
                    $display("FAIL b2b_sonuc100 j=%0d got %0d exp 100", j, sonuc);
                end
            end
            if (j == c + 36) begin
                checks++;
                if (sonuc !== 32'd125) begin
                    errors++;
                    $display("FAIL b2b_sonuc125 got %0d exp 125", sonuc);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        gecerli    = 1'b0;
        islem      = '0;
        bolunen    = '0;
        bolen      = '0;
        bosalt     = 1'b0;
        durdur     = 1'b0;
        stub_sifir = 1'b0;
        test_reset();
        test_div_neg();
        test_durdur();
        test_bosalt();
        test_watchdog();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
